// File: rtl/fetch_unit.sv
// Instruction fetch front-end: walks a word-addressed PC through a 1-cycle ROM,
// buffers responses in a small FIFO and hands them to the core over valid/ready.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [31:0]                  imem_rdata,
    output logic                         instr_valid,
    output logic [31:0]                  instr,
    output logic [ADDR_W-1:0]            instr_pc,
    input  logic                         instr_ready,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;

    logic [CW:0]       credit;
    logic              fire;
    logic              push;
    logic              pop;

    // Credit counts the outstanding read as occupied, so a response always has a slot.
    assign credit      = {1'b0, count} + (CW + 1)'(inflight);
    assign fire        = en & ~redirect & (credit < (CW + 1)'(DEPTH));
    assign push        = inflight & ~redirect;
    assign pop         = instr_valid & instr_ready;

    assign imem_addr   = pc;
    assign fifo_count  = count;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? mem[rd_ptr].instr : '0;
    assign instr_pc    = instr_valid ? mem[rd_ptr].pc    : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            // NOTE: the FIFO storage is cleared too, so no stale word survives a reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= fire;
            if (fire) begin
                inflight_pc <= pc;
                pc          <= pc + ADDR_W'(1);
            end
            if (push) begin
                mem[wr_ptr] <= {imem_rdata, inflight_pc};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM word at address a is 0x100 + a, so every
// delivered instruction must equal 0x100 + its pc.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    fetch_unit #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) imem_rdata <= 32'h100 + 32'(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects n consecutive handshakes (instr_ready must be 1) starting at first_pc.
    task automatic expect_stream(input string tag, input int n, input logic [7:0] first_pc);
        logic [7:0] p;
        p = first_pc;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, 32'(instr_valid), 32'd1);
            check({tag, "_pc"}, 32'(instr_pc), 32'(p));
            check({tag, "_instr"}, instr, 32'h100 + 32'(p));
            p = p + 8'd1;
            step();
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step();
        step();
        check("rst_addr", 32'(imem_addr), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", 32'(instr_pc), 32'h0);
        check("rst_count", 32'(fifo_count), 32'd0);

        // Startup: address 0 in cycle 0, first valid in cycle 2.
        rst = 1'b1; en = 1'b1; instr_ready = 1'b1;
        check("c0_addr", 32'(imem_addr), 32'h0);
        step();
        check("c1_valid", 32'(instr_valid), 32'd0);
        check("c1_addr", 32'(imem_addr), 32'h1);
        step();
        expect_stream("stream", 5, 8'h00);

        // Backpressure: head pc 5, FIFO saturates with pc 5..8, pc reg stops at 9.
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("bp_count", 32'(fifo_count), 32'd4);
        check("bp_addr", 32'(imem_addr), 32'h9);
        check("bp_head", 32'(instr_pc), 32'h5);
        instr_ready = 1'b1;
        expect_stream("drain", 8, 8'h05);

        // Redirect while the head is pc 16.
        for (int i = 0; i < 20 && instr_pc != 8'd16; i++) step();
        check("redir_head", 32'(instr_pc), 32'd16);
        check("redir_hs_valid", 32'(instr_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 8'h40;
        step();
        redirect = 1'b0;
        check("redir_t1_count", 32'(fifo_count), 32'd0);
        check("redir_t1_valid", 32'(instr_valid), 32'd0);
        check("redir_t1_addr", 32'(imem_addr), 32'h40);
        step();
        check("redir_t2_valid", 32'(instr_valid), 32'd0);
        check("redir_t2_addr", 32'(imem_addr), 32'h41);
        step();
        expect_stream("redir", 4, 8'h40);

        // PC wrap across 0xFF.
        redirect = 1'b1; redirect_pc = 8'hFC;
        step();
        redirect = 1'b0;
        step();
        step();
        expect_stream("wrap", 6, 8'hFC);

        // en low for 5 cycles: head pc 2 and in-flight pc 3 still delivered.
        en = 1'b0;
        expect_stream("en_off", 2, 8'h02);
        for (int i = 0; i < 3; i++) begin
            check("en_off_valid", 32'(instr_valid), 32'd0);
            check("en_off_addr", 32'(imem_addr), 32'h04);
            step();
        end
        en = 1'b1;
        check("en_on_addr", 32'(imem_addr), 32'h04);
        step();
        check("en_on_valid", 32'(instr_valid), 32'd0);
        step();
        expect_stream("en_on", 3, 8'h04);

        // Reset with a full FIFO.
        instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("full_count", 32'(fifo_count), 32'd4);
        rst = 1'b0;
        step();
        check("mrst_valid", 32'(instr_valid), 32'd0);
        check("mrst_count", 32'(fifo_count), 32'd0);
        check("mrst_addr", 32'(imem_addr), 32'h0);
        check("mrst_instr", instr, 32'h0);
        rst = 1'b1; instr_ready = 1'b1;
        step();
        check("mrst_c1_valid", 32'(instr_valid), 32'd0);
        step();
        expect_stream("restart", 3, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
